// File: rtl/led_mode_sequencer_if.sv
// Control/status bundle of the LED mode sequencer: step strobe and button in,
// LED drive and mode status out.
interface led_mode_sequencer_if;
  logic       tick_enable;
  logic       btn_in_n;
  logic       led;
  logic [1:0] mode;
  logic       mode_change;

  modport master (
    output tick_enable,
    output btn_in_n,
    input  led,
    input  mode,
    input  mode_change
  );

  modport slave (
    input  tick_enable,
    input  btn_in_n,
    output led,
    output mode,
    output mode_change
  );
endinterface

// File: rtl/led_mode_sequencer.sv
// Button-selected LED pattern generator (OFF / ON / BLINK / HEARTBEAT).
// Press latency: btn_in_n sampled low at edge 1 -> mode_change high right after edge DEBOUNCE_CYCLES+4.
module led_mode_sequencer #(
  parameter int         CLK_FREQ          = 27_000_000,
  parameter int         DEBOUNCE_MS       = 20,
  parameter logic [7:0] HEARTBEAT_PATTERN = 8'b1010_0000
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst_n,
  led_mode_sequencer_if.slave   bus
);

  localparam int DEB_RAW         = CLK_FREQ / 1000 * DEBOUNCE_MS;
  localparam int DEBOUNCE_CYCLES = (DEB_RAW < 1) ? 1 : DEB_RAW;
  localparam int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    MODE_OFF   = 2'd0,
    MODE_ON    = 2'd1,
    MODE_BLINK = 2'd2,
    MODE_HEART = 2'd3
  } mode_e;

  logic             r_sync1;
  logic             r_sync2;
  logic             r_deb;
  logic             r_deb_q;
  logic [CNT_W-1:0] r_cnt;
  logic             r_press;
  mode_e            r_mode;
  logic             r_mode_chg;
  logic [2:0]       r_step;
  logic             r_led;

  logic             w_differ;
  logic             w_accept;
  logic             w_press;
  mode_e            w_mode_nxt;
  logic             w_chg_nxt;
  logic             w_led_nxt;

  // Two-flop synchronizer; idles at released (1)
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= bus.btn_in_n;
      r_sync2 <= r_sync1;
    end
  end

  // Debouncer: accept a new level after DEBOUNCE_CYCLES consecutive differing samples
  assign w_differ = r_sync2 ^ r_deb;
  assign w_accept = w_differ && (r_cnt == CNT_LAST);

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_deb <= 1'b1;
      r_cnt <= '0;
    end else if (w_accept) begin
      r_deb <= r_sync2;
      r_cnt <= '0;
    end else if (w_differ) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end else begin
      r_cnt <= '0;
    end
  end

  // Press event: released -> pressed edge of the debounced level only
  assign w_press = r_deb_q & ~r_deb;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_deb_q <= 1'b1;
      r_press <= 1'b0;
    end else begin
      r_deb_q <= r_deb;
      r_press <= w_press;
    end
  end

  // Mode FSM: state register
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_mode     <= MODE_BLINK;
      r_mode_chg <= 1'b0;
    end else begin
      r_mode     <= w_mode_nxt;
      r_mode_chg <= w_chg_nxt;
    end
  end

  // Mode FSM: one advance per press, wrapping HEARTBEAT back to OFF
  always_comb begin
    w_mode_nxt = r_mode;
    w_chg_nxt  = 1'b0;
    if (r_press) begin
      w_chg_nxt = 1'b1;
      case (r_mode)
        MODE_OFF:   w_mode_nxt = MODE_ON;
        MODE_ON:    w_mode_nxt = MODE_BLINK;
        MODE_BLINK: w_mode_nxt = MODE_HEART;
        default:    w_mode_nxt = MODE_OFF;
      endcase
    end
  end

  // Step counter: a press clears it and swallows any coincident tick
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_step <= '0;
    end else if (r_press) begin
      r_step <= '0;
    end else if (r_mode == MODE_OFF || r_mode == MODE_ON) begin
      r_step <= '0;
    end else if (bus.tick_enable) begin
      r_step <= r_step + 3'd1;
    end
  end

  always_comb begin
    w_led_nxt = 1'b0;
    case (r_mode)
      MODE_OFF:   w_led_nxt = 1'b0;
      MODE_ON:    w_led_nxt = 1'b1;
      MODE_BLINK: w_led_nxt = r_step[0];
      default:    w_led_nxt = HEARTBEAT_PATTERN[3'd7 - r_step];
    endcase
  end

  // LED register: one cycle behind step/mode, no input-to-output path
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_led <= 1'b0;
    end else begin
      r_led <= w_led_nxt;
    end
  end

  assign bus.led         = r_led;
  assign bus.mode        = r_mode;
  assign bus.mode_change = r_mode_chg;

endmodule
